// File: rtl/test_ctrl_pkg.sv
// test_ctrl_pkg: shared types and helpers for the test_ctrl run-control block.
//   - state_e      : run-control FSM state encoding (3 bits)
//   - STAT_*       : bit positions inside the packed done/pass status vector
//   - cnt_width()  : counter width able to hold values 0 .. n-1 (minimum 1 bit)
package test_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_e;

  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_PASS = 1;
  localparam int unsigned STAT_W    = 2;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((longint'(1) << w) < longint'(n)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/test_ctrl_sync.sv
// test_ctrl_sync: WIDTH-bit, STAGES-deep flop synchronizer for signals
// asynchronous to clk. All stages clear to 0 on rst_n low.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d_i    in  WIDTH  asynchronous input bus
//   q_o    out WIDTH  synchronised bus (STAGES cycles of latency)
module test_ctrl_sync
  import test_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES < 2) begin : g_err_stages
    $error("test_ctrl_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/test_ctrl.sv
// test_ctrl: run-control block. Holds the core in reset for RST_CYCLES cycles
// after a start edge, releases it, counts run cycles and stops on the rising
// edge of the synchronised EOC gpio bit, capturing the PASS bit alongside.
// Optional watchdog (macro TEST_CTRL_WATCHDOG_EN) ends a run that reaches
// TIMEOUT_CYCLES without EOC; without the macro timeout_o is tied 0.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   start_i      in   level; rising edge launches (or restarts) a run
//   gpio_i       in   GPIO_WIDTH core gpio, asynchronous to clk
//   core_rst_no  out  active-low reset to the core
//   running_o    out  core released and executing
//   done_o       out  EOC seen, sticky until next start
//   pass_o       out  PASS_BIT captured at EOC
//   timeout_o    out  watchdog expired, sticky until next start
//   cycle_cnt_o  out  CNT_W run cycles since core release (saturating)
//
// state   | meaning
// IDLE    | core held in reset, waiting for a start edge
// HOLD    | core held in reset, hold counter running down
// RUN     | core released, counting cycles, watching EOC
// DONE    | EOC seen; core left out of reset for inspection
// TIMEOUT | watchdog expired; core re-held in reset
module test_ctrl
  import test_ctrl_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH     = 32,
  parameter int unsigned EOC_BIT        = 14,
  parameter int unsigned PASS_BIT       = 15,
  parameter int unsigned RST_CYCLES     = 500,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic                  core_rst_no,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      cycle_cnt_o
);

  if (RST_CYCLES == 0) begin : g_err_rst
    $error("test_ctrl: RST_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_err_timeout
    $error("test_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  localparam int unsigned     HCW       = cnt_width(RST_CYCLES);
  localparam logic [HCW-1:0]  HOLD_INIT = HCW'(RST_CYCLES - 1);

  // start edge detect
  logic start_q, start_q_d, start_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      start_q_d <= 1'b0;
    end else begin
      start_q   <= start_i;
      start_q_d <= start_q;
    end
  end

  assign start_evt = start_q & ~start_q_d;

  // gpio synchronisation and EOC edge detect
  logic [GPIO_WIDTH-1:0] gpio_sync;
  logic                  eoc_s, pass_s, eoc_q, eoc_rise;
  logic                  unused_gpio;

  test_ctrl_sync #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (gpio_i),
    .q_o   (gpio_sync)
  );

  assign eoc_s       = gpio_sync[EOC_BIT];
  assign pass_s      = gpio_sync[PASS_BIT];
  assign unused_gpio = ^gpio_sync;

  // eoc_q follows EOC in every state, so a level already high at release
  // produces no edge until it drops and rises again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_q <= 1'b0;
    end else begin
      eoc_q <= eoc_s;
    end
  end

  assign eoc_rise = eoc_s & ~eoc_q;

  // FSM
  state_e              state_q, state_d;
  logic [HCW-1:0]      hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STAT_W-1:0]   stat_q, stat_d;

`ifdef TEST_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_q, timeout_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
    end
  end

`ifdef TEST_CTRL_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    stat_d  = stat_q;
`ifdef TEST_CTRL_WATCHDOG_EN
    timeout_d = timeout_q;
`endif

    // a start edge restarts the sequence from any state
    if (start_evt) begin
      state_d = HOLD;
      hold_d  = HOLD_INIT;
      cnt_d   = '0;
      stat_d  = '0;
`ifdef TEST_CTRL_WATCHDOG_EN
      timeout_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        HOLD: begin
          if (hold_q == '0) begin
            state_d = RUN;
          end else begin
            hold_d = hold_q - HCW'(1);
          end
        end
        RUN: begin
          // the cycle that decides to leave RUN does not count, so the
          // counter freezes at the value seen when the decision was made
          if (eoc_rise) begin
            state_d           = DONE;
            stat_d[STAT_DONE] = 1'b1;
            stat_d[STAT_PASS] = pass_s;
          end
`ifdef TEST_CTRL_WATCHDOG_EN
          else if (cnt_q == TO_LAST) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end
`endif
          else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE, TIMEOUT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign core_rst_no = (state_q == RUN) || (state_q == DONE);
  assign running_o   = (state_q == RUN);
  assign done_o      = stat_q[STAT_DONE];
  assign pass_o      = stat_q[STAT_PASS];
  assign cycle_cnt_o = cnt_q;

`ifdef TEST_CTRL_WATCHDOG_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
